// File: rtl/seq_stage_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : y86_pkg
//  Purpose  : Shared Y-86 encodings for the SEQ stage controller: icodes,
//             status codes, controller state encoding, icode helpers.
//  Revision : 1.0  initial release
// ============================================================================
package y86_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Processor status codes
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   // Controller states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_PCUPD     = 3'd6,
      ST_HALT      = 3'd7
   } ctrl_state_t;

   // Instructions that touch data memory and therefore need the req/ack handshake
   function automatic logic is_mem_icode(input logic [3:0] icode);
      return (icode == IRMMOVQ) || (icode == IMRMOVQ) || (icode == ICALL) ||
             (icode == IRET)    || (icode == IPUSHQ)  || (icode == IPOPQ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_stage_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_stage_controller_if
//  Purpose  : Bundle between the SEQ controller and the fetch/execute/memory
//             datapath. master = controller, slave = datapath side.
//  Revision : 1.0  initial release
// ============================================================================
interface seq_stage_controller_if #(
   parameter int CNT_W = 32
);
   import y86_pkg::*;

   // Datapath -> controller
   logic              start;
   logic              run;
   logic [3:0]        icode;
   logic              Cnd;
   logic [63:0]       valC;
   logic [63:0]       valP;
   logic [63:0]       valM;
   logic              instruct_err;
   logic              imem_err;
   logic              mem_ack;
   logic              dmem_err;

   // Controller -> datapath
   logic [63:0]       PC;
   logic              fetch_en;
   logic              decode_en;
   logic              execute_en;
   logic              memory_en;
   logic              writeback_en;
   logic              mem_req;
   logic [2:0]        stat;
   logic              halted;
   logic [CNT_W-1:0]  instr_count;

   modport master (
      input  start, run, icode, Cnd, valC, valP, valM,
             instruct_err, imem_err, mem_ack, dmem_err,
      output PC, fetch_en, decode_en, execute_en, memory_en, writeback_en,
             mem_req, stat, halted, instr_count
   );

   modport slave (
      output start, run, icode, Cnd, valC, valP, valM,
             instruct_err, imem_err, mem_ack, dmem_err,
      input  PC, fetch_en, decode_en, execute_en, memory_en, writeback_en,
             mem_req, stat, halted, instr_count
   );

endinterface
`default_nettype wire

// File: rtl/seq_stage_controller_pc_select.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pc_select
//  Purpose  : Combinational next-PC mux: call and taken jump go to valC,
//             ret goes to the latched memory word, all else falls through.
//  Revision : 1.0  initial release
// ============================================================================
module seq_pc_select
   import y86_pkg::*;
(
   input  logic [3:0]  i_icode,
   input  logic        i_cnd,
   input  logic [63:0] i_valc,
   input  logic [63:0] i_valp,
   input  logic [63:0] i_valm,
   output logic [63:0] o_next_pc
);

   // Next-PC priority mux
   always_comb begin
      o_next_pc = i_valp;
      if (i_icode == ICALL) begin
         o_next_pc = i_valc;
      end else if ((i_icode == IJXX) && i_cnd) begin
         o_next_pc = i_valc;
      end else if (i_icode == IRET) begin
         o_next_pc = i_valm;
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_stage_controller.sv
`default_nettype none
// ============================================================================
//  Module   : seq_stage_controller
//  Purpose  : Multi-cycle Y-86 SEQ sequencer. Owns the PC, strobes one stage
//             per cycle, handshakes with data memory and tracks status.
//  Revision : 1.0  initial release
// ============================================================================
module seq_stage_controller
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'd0,
   parameter int          CNT_W    = 32
)(
   input  logic                  clk,
   input  logic                  rst,
   seq_stage_controller_if.master bus
);

   ctrl_state_t        r_state;
   logic [63:0]        r_pc;
   logic [63:0]        r_valm;
   logic [3:0]         r_icode;
   logic [2:0]         r_stat;
   logic [CNT_W-1:0]   r_instr_count;

   logic [63:0]        w_next_pc;
   logic               w_mem_instr;

   // icode is captured in DECODE so MEMORY/PCUPD see a stable value
   assign w_mem_instr = is_mem_icode(r_icode);

   seq_pc_select u_pc_select (
      .i_icode   (r_icode),
      .i_cnd     (bus.Cnd),
      .i_valc    (bus.valC),
      .i_valp    (bus.valP),
      .i_valm    (r_valm),
      .o_next_pc (w_next_pc)
   );

   // Sequencer FSM with PC, status, retired count and ret-address latch
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_pc          <= RESET_PC;
         r_valm        <= 64'd0;
         r_icode       <= INOP;
         r_stat        <= SAOK;
         r_instr_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               // Address errors outrank invalid-instruction errors
               if (bus.imem_err) begin
                  r_stat  <= SADR;
                  r_state <= ST_HALT;
               end else if (bus.instruct_err) begin
                  r_stat  <= SINS;
                  r_state <= ST_HALT;
               end else begin
                  r_state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               r_icode <= bus.icode;
               if (bus.icode > IPOPQ) begin
                  r_stat  <= SINS;
                  r_state <= ST_HALT;
               end else if (bus.icode == IHALT) begin
                  r_stat  <= SHLT;
                  r_state <= ST_HALT;
               end else begin
                  r_state <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               r_state <= ST_MEMORY;
            end
            ST_MEMORY: begin
               if (w_mem_instr) begin
                  // Request is held until the ack cycle; leave on the ack itself
                  if (bus.mem_ack) begin
                     r_valm <= bus.valM;
                     if (bus.dmem_err) begin
                        r_stat  <= SADR;
                        r_state <= ST_HALT;
                     end else begin
                        r_state <= ST_WRITEBACK;
                     end
                  end
               end else begin
                  r_state <= ST_WRITEBACK;
               end
            end
            ST_WRITEBACK: begin
               r_state <= ST_PCUPD;
            end
            ST_PCUPD: begin
               r_pc          <= w_next_pc;
               r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
               r_state       <= bus.run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
               r_state <= ST_HALT;
            end
         endcase
      end
   end

   // Outputs: registers or pure state decodes only
   assign bus.PC           = r_pc;
   assign bus.fetch_en     = (r_state == ST_FETCH);
   assign bus.decode_en    = (r_state == ST_DECODE);
   assign bus.execute_en   = (r_state == ST_EXECUTE);
   assign bus.memory_en    = (r_state == ST_MEMORY);
   assign bus.writeback_en = (r_state == ST_WRITEBACK);
   assign bus.mem_req      = (r_state == ST_MEMORY) && w_mem_instr;
   assign bus.stat         = r_stat;
   assign bus.halted       = (r_state == ST_HALT);
   assign bus.instr_count  = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_stage_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_stage_controller
//  Purpose  : Scoreboard bench for seq_stage_controller. Directed instructions
//             push expected retire/halt records; a monitor pops and compares.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_stage_controller;

   localparam logic [63:0] RST_PC = 64'd66;

   typedef struct {
      bit          halt;
      logic [63:0] pc;
      logic [2:0]  stat;
      int          cnt;
      int          lat;     // -1: not checked
      int          memc;
      bit          wb;
   } exp_t;

   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   ev_count;
   exp_t sb[$];

   // memory responder configuration
   int          ack_delay;
   logic        cfg_derr;
   logic [63:0] cfg_valm;
   int          reqcnt;

   // monitor state
   logic [31:0] prev_cnt;
   logic        prev_halt;
   int          m_cyc;
   int          m_memc;
   bit          m_wb;
   bit          m_ord;
   int          m_last;
   int          m_k;
   logic [4:0]  m_s;
   exp_t        m_e;

   seq_stage_controller_if #(.CNT_W(32)) bus();

   seq_stage_controller #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input bit h, input logic [63:0] pc, input logic [2:0] st,
                           input int cnt, input int lat, input int memc, input bit wb);
      exp_t e;
      e.halt = h; e.pc = pc; e.stat = st; e.cnt = cnt;
      e.lat = lat; e.memc = memc; e.wb = wb;
      sb.push_back(e);
   endtask

   // Data-memory responder: ack after ack_delay cycles of request
   always @(negedge clk) begin
      if (rst) begin
         bus.mem_ack  = 1'b0;
         bus.dmem_err = 1'b0;
         bus.valM     = 64'hDEAD_BEEF_DEAD_BEEF;
         reqcnt       = 0;
      end else if (bus.mem_req) begin
         if (reqcnt == ack_delay) begin
            bus.mem_ack  = 1'b1;
            bus.dmem_err = cfg_derr;
            bus.valM     = cfg_valm;
         end else begin
            bus.mem_ack  = 1'b0;
            bus.dmem_err = 1'b0;
            bus.valM     = 64'hDEAD_BEEF_DEAD_BEEF;
         end
         reqcnt++;
      end else begin
         bus.mem_ack  = 1'b0;
         bus.dmem_err = 1'b0;
         bus.valM     = 64'hDEAD_BEEF_DEAD_BEEF;
         reqcnt       = 0;
      end
   end

   // Monitor: detects retire (count change) and halt entry, compares to scoreboard
   always @(negedge clk) begin
      if (rst) begin
         prev_cnt  = 32'd0;
         prev_halt = 1'b0;
         m_cyc = 0; m_memc = 0; m_wb = 0; m_ord = 1; m_last = 0;
      end else begin
         if ((bus.instr_count != prev_cnt) || (bus.halted && !prev_halt)) begin
            ev_count++;
            if (sb.size() == 0) begin
               errors++;
               checks++;
               $display("FAIL unexpected_event: got event pc=%h stat=%0d, expected none",
                        bus.PC, bus.stat);
            end else begin
               m_e = sb.pop_front();
               chk("event_is_halt", {63'd0, bus.halted}, {63'd0, m_e.halt});
               chk("pc",            bus.PC, m_e.pc);
               chk("stat",          {61'd0, bus.stat}, {61'd0, m_e.stat});
               chk("instr_count",   {32'd0, bus.instr_count}, 64'(m_e.cnt));
               chk("writeback_seen",{63'd0, m_wb}, {63'd0, m_e.wb});
               chk("mem_req_cycles",64'(m_memc), 64'(m_e.memc));
               chk("strobe_order",  {63'd0, m_ord}, 64'd1);
               if (m_e.lat >= 0) chk("latency", 64'(m_cyc), 64'(m_e.lat));
            end
         end
         m_s = {bus.writeback_en, bus.memory_en, bus.execute_en, bus.decode_en, bus.fetch_en};
         case (m_s)
            5'b00001: m_k = 1;
            5'b00010: m_k = 2;
            5'b00100: m_k = 3;
            5'b01000: m_k = 4;
            5'b10000: m_k = 5;
            5'b00000: m_k = 0;
            default:  m_k = 9;
         endcase
         if (bus.fetch_en) begin
            m_cyc = 1; m_memc = 0; m_wb = 0; m_last = 1;
            m_ord = (m_k == 1);
         end else if (m_cyc != 0) begin
            m_cyc++;
            if (m_k != 0) begin
               if (!((m_k == m_last + 1) || (m_k == 4 && m_last == 4))) m_ord = 0;
               m_last = m_k;
            end
            if (bus.mem_req) m_memc++;
            if (bus.writeback_en) m_wb = 1;
         end
         prev_cnt  = bus.instr_count;
         prev_halt = bus.halted;
      end
   end

   task automatic wait_ev(input int n_before, input string nm);
      int k;
      k = 0;
      while (ev_count == n_before && k < 60) begin
         @(negedge clk); #1;
         k++;
      end
      if (ev_count == n_before) begin
         errors++;
         checks++;
         $display("FAIL timeout_%s: got no event in 60 cycles, expected one", nm);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.instruct_err = 1'b0; bus.imem_err = 1'b0;
      ack_delay = 0; cfg_derr = 1'b0;
      @(negedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic issue(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                        input logic cnd, input logic rn);
      bus.icode = ic; bus.valC = vc; bus.valP = vp; bus.Cnd = cnd; bus.run = rn;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic run_one(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp,
                          input logic cnd, input string nm);
      int n;
      n = ev_count;
      issue(ic, vc, vp, cnd, 1'b0);
      wait_ev(n, nm);
   endtask

   initial begin
      int n;
      int k;
      errors = 0; checks = 0; ev_count = 0;
      ack_delay = 0; cfg_derr = 1'b0; cfg_valm = 64'd0;
      rst = 1'b1;
      bus.start = 1'b0; bus.run = 1'b0; bus.icode = 4'h1; bus.Cnd = 1'b0;
      bus.valC = 64'd0; bus.valP = 64'd0; bus.instruct_err = 1'b0; bus.imem_err = 1'b0;
      @(negedge clk); @(negedge clk); #1;

      // Reset state
      chk("rst_pc",      bus.PC, RST_PC);
      chk("rst_stat",    {61'd0, bus.stat}, 64'd1);
      chk("rst_count",   {32'd0, bus.instr_count}, 64'd0);
      chk("rst_halted",  {63'd0, bus.halted}, 64'd0);
      chk("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
      chk("rst_strobes", {59'd0, bus.writeback_en, bus.memory_en, bus.execute_en,
                          bus.decode_en, bus.fetch_en}, 64'd0);
      rst = 1'b0;

      // irmovq, single step
      push_exp(0, 64'd76, 3'd1, 1, 6, 0, 1);
      run_one(4'h3, 64'd0, 64'd76, 1'b0, "irmovq");
      repeat (3) begin @(negedge clk); end
      #1;
      chk("idle_no_fetch", {63'd0, bus.fetch_en}, 64'd0);
      chk("idle_pc_hold",  bus.PC, 64'd76);

      // jXX taken / not taken
      push_exp(0, 64'd34, 3'd1, 2, 6, 0, 1);
      run_one(4'h7, 64'd34, 64'd100, 1'b1, "jxx_taken");
      push_exp(0, 64'd100, 3'd1, 3, 6, 0, 1);
      run_one(4'h7, 64'd34, 64'd100, 1'b0, "jxx_not_taken");

      // rmmovq, ack 3 cycles after first request
      ack_delay = 3;
      push_exp(0, 64'd110, 3'd1, 4, 9, 4, 1);
      run_one(4'h4, 64'd0, 64'd110, 1'b0, "rmmovq");

      // call, ack in the first request cycle
      ack_delay = 0;
      push_exp(0, 64'd200, 3'd1, 5, 6, 1, 1);
      run_one(4'h8, 64'd200, 64'd120, 1'b0, "call");

      // ret, PC from the word latched on the ack cycle
      ack_delay = 1; cfg_valm = 64'h1234;
      push_exp(0, 64'h1234, 3'd1, 6, 7, 2, 1);
      run_one(4'h9, 64'd0, 64'd210, 1'b0, "ret");

      // continuous run: nop then halt fetched straight after
      ack_delay = 0;
      push_exp(0, 64'h300, 3'd1, 7, 6, 0, 1);
      n = ev_count;
      issue(4'h1, 64'd0, 64'h300, 1'b0, 1'b1);
      wait_ev(n, "run_nop");
      bus.icode = 4'h0;
      push_exp(1, 64'h300, 3'd2, 7, -1, 0, 0);
      n = ev_count;
      wait_ev(n, "run_halt");
      bus.run = 1'b0;
      issue(4'h1, 64'd0, 64'h400, 1'b0, 1'b0);
      repeat (4) begin @(negedge clk); end
      #1;
      chk("halt_terminal", {63'd0, bus.halted}, 64'd1);
      chk("halt_no_fetch", {63'd0, bus.fetch_en}, 64'd0);

      // halt at PC 0
      do_reset();
      chk("rst2_pc",    bus.PC, RST_PC);
      chk("rst2_count", {32'd0, bus.instr_count}, 64'd0);
      push_exp(0, 64'd0, 3'd1, 1, 6, 0, 1);
      run_one(4'h7, 64'd0, 64'd90, 1'b1, "jmp_to_0");
      push_exp(1, 64'd0, 3'd2, 1, -1, 0, 0);
      run_one(4'h0, 64'd0, 64'd1, 1'b0, "halt_pc0");

      // invalid instruction byte C0 flagged by fetch
      do_reset();
      bus.instruct_err = 1'b1;
      push_exp(1, RST_PC, 3'd4, 0, -1, 0, 0);
      run_one(4'hC, 64'd0, 64'd70, 1'b0, "instruct_err");

      // address error outranks invalid instruction
      do_reset();
      bus.instruct_err = 1'b1; bus.imem_err = 1'b1;
      push_exp(1, RST_PC, 3'd3, 0, -1, 0, 0);
      run_one(4'hC, 64'd0, 64'd70, 1'b0, "imem_err");

      // icode beyond IPOPQ caught in decode
      do_reset();
      push_exp(1, RST_PC, 3'd4, 0, -1, 0, 0);
      run_one(4'hD, 64'd0, 64'd70, 1'b0, "bad_icode");

      // mrmovq with data-memory error on the ack
      do_reset();
      ack_delay = 2; cfg_derr = 1'b1;
      push_exp(1, RST_PC, 3'd3, 0, -1, 3, 0);
      run_one(4'h5, 64'd0, 64'd76, 1'b0, "dmem_err");
      cfg_derr = 1'b0;

      // reset in the middle of a memory wait, then a fresh instruction
      do_reset();
      push_exp(0, 64'd80, 3'd1, 1, 6, 0, 1);
      run_one(4'h3, 64'd0, 64'd80, 1'b0, "pre_wait");
      ack_delay = 1000;
      issue(4'h4, 64'd0, 64'd88, 1'b0, 1'b0);
      k = 0;
      while (!bus.mem_req && k < 20) begin
         @(negedge clk); #1;
         k++;
      end
      chk("req_before_reset", {63'd0, bus.mem_req}, 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_mem_req", {63'd0, bus.mem_req}, 64'd0);
      chk("midrst_pc",      bus.PC, RST_PC);
      chk("midrst_stat",    {61'd0, bus.stat}, 64'd1);
      chk("midrst_count",   {32'd0, bus.instr_count}, 64'd0);
      @(negedge clk); #1;
      rst = 1'b0;
      ack_delay = 0;
      push_exp(0, 64'd90, 3'd1, 1, 6, 0, 1);
      run_one(4'h3, 64'd0, 64'd90, 1'b0, "after_reset");

      repeat (2) begin @(negedge clk); end
      while (sb.size() > 0) begin
         m_e = sb.pop_front();
         errors++;
         checks++;
         $display("FAIL missing_event: got nothing, expected pc=%h stat=%0d", m_e.pc, m_e.stat);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
